fb_scan_scheduler: RTL and testbench

- Shares the single-port 320x240 RGB888 frame memory between two requesters: scanout line prefetch and a pixel writer.
- Scanout prefetch copies one source line into a ping-pong line buffer ahead of display; the 2x-scaling scanout path reads that buffer.
- The writer is a CPU/UART image loader using a valid/ready handshake.
- Sits between the video timing counters (pixel clock domain) and the frame memory BSRAM.

---
 rtl/fb_scan_scheduler.sv | 154 +++++++++++++++
 tb/tb_fb_scan_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scan_scheduler.sv
// Frame-memory arbiter: scanout line prefetch into a ping-pong line buffer vs a valid/ready pixel writer.
// Line-buffer write lands 1 cycle after each read; under contention the writer only waits out fetch-read slots.
module fb_scan_scheduler #(
  parameter int SRC_WIDTH  = 320,
  parameter int SRC_HEIGHT = 240,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic [7:0]        fetch_line,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [8:0]        lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_overrun
);

  localparam int IDX_W = 9;
  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(SRC_WIDTH * SRC_HEIGHT);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(SRC_WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_FETCH} state_t;

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic              bank_q, bank_d;
  logic              lb_bank_q, lb_bank_d;
  logic              alt_q, alt_d;
  logic              err_q, err_d;
  logic              rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic busy;
  logic accept;
  logic rd_issue;
  logic line_ok;
  logic wr_in_range;

  assign busy        = (state_q == ST_FETCH) || rd_pend_q;
  assign line_ok     = int'(fetch_line) < SRC_HEIGHT;
  assign accept      = fetch_start && !busy && line_ok;
  assign wr_in_range = wr_addr < FB_WORDS;

  // Memory port: one op per cycle. alt_q set means the last contended slot went to the fetch.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ready  = 1'b0;
    rd_issue  = 1'b0;
    alt_d     = alt_q;
    if (state_q == ST_FETCH) begin
      if (wr_valid && alt_q) begin
        wr_ready = 1'b1;
        alt_d    = 1'b0;
        if (wr_in_range) begin
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
      end else begin
        rd_issue = 1'b1;
        mem_re   = 1'b1;
        mem_addr = base_q + ADDR_W'(idx_q);
        alt_d    = 1'b1;
      end
    end else if (run_q) begin
      // run_q keeps the writer grant low until the first clock after reset release.
      wr_ready = 1'b1;
      if (wr_valid && wr_in_range) begin
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = 1'b1;
    bank_d    = bank_q;
    lb_bank_d = lb_bank_q;
    idx_d     = idx_q;
    base_d    = base_q;
    rd_pend_d = rd_issue;
    rd_idx_d  = rd_issue ? idx_q : rd_idx_q;
    err_d     = err_q | (fetch_start && (busy || !line_ok));
    if (accept) begin
      state_d   = ST_FETCH;
      base_d    = ADDR_W'(fetch_line) * ADDR_W'(SRC_WIDTH);
      idx_d     = '0;
      lb_bank_d = bank_q;
      bank_d    = ~bank_q;
    end
    if (rd_issue) begin
      if (idx_q == IDX_LAST) begin
        state_d = ST_IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      bank_q    <= 1'b0;
      lb_bank_q <= 1'b0;
      alt_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      idx_q     <= '0;
      rd_idx_q  <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      bank_q    <= bank_d;
      lb_bank_q <= lb_bank_d;
      alt_q     <= alt_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
      idx_q     <= idx_d;
      rd_idx_q  <= rd_idx_d;
      base_q    <= base_d;
    end
  end

  assign fetch_busy  = busy;
  assign lb_we       = rd_pend_q;
  assign lb_bank     = rd_pend_q & lb_bank_q;
  assign lb_addr     = rd_pend_q ? rd_idx_q : '0;
  assign lb_wdata    = rd_pend_q ? mem_rdata : '0;
  assign fetch_done  = rd_pend_q && (rd_idx_q == IDX_LAST);
  assign err_overrun = err_q;

endmodule

// File: tb/tb_fb_scan_scheduler.sv
// Directed bench for fb_scan_scheduler: writer vector table plus multi-cycle fetch sequences.
module tb_fb_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start;
  logic [7:0]  fetch_line;
  logic        fetch_busy, fetch_done, lb_we, lb_bank;
  logic [8:0]  lb_addr;
  logic [23:0] lb_wdata;
  logic        wr_valid, wr_ready;
  logic [16:0] wr_addr;
  logic [23:0] wr_data;
  logic [16:0] mem_addr;
  logic        mem_re, mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic        err_overrun;

  fb_scan_scheduler dut (
    .clk(clk), .rst(rst_n),
    .fetch_start(fetch_start), .fetch_line(fetch_line),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input logic [16:0] a);
    return {7'h55, a};
  endfunction

  // Frame memory: read data appears the cycle after mem_re.
  always @(posedge clk) mem_rdata <= mem_re ? pix(mem_addr) : 24'h0;

  int errors = 0;
  int checks = 0;
  int cyc;

  int n_re, first_re, last_re, re_odd, addr_bad;
  int n_lb, first_lb, last_lb, bank_bad, lbaddr_bad, data_bad;
  int n_done, done_cyc, n_busy, busy_first, busy_last;
  int n_both, n_we, n_gwin, win_lo, win_hi;
  int exp_base;
  logic exp_bank;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats(input int base, input logic bank);
    n_re = 0; first_re = -1; last_re = -1; re_odd = 0; addr_bad = 0;
    n_lb = 0; first_lb = -1; last_lb = -1; bank_bad = 0; lbaddr_bad = 0; data_bad = 0;
    n_done = 0; done_cyc = -1; n_busy = 0; busy_first = -1; busy_last = -1;
    n_both = 0; n_we = 0; n_gwin = 0;
    exp_base = base; exp_bank = bank; cyc = 0;
  endtask

  task automatic sample();
    if (mem_re && mem_we) n_both++;
    if (mem_re) begin
      if (n_re == 0) first_re = cyc;
      last_re = cyc;
      if (int'(mem_addr) != exp_base + n_re) addr_bad++;
      if ((cyc % 2) != 0) re_odd++;
      n_re++;
    end
    if (mem_we) n_we++;
    if (wr_valid && wr_ready && cyc >= win_lo && cyc <= win_hi) n_gwin++;
    if (lb_we) begin
      if (n_lb == 0) first_lb = cyc;
      last_lb = cyc;
      if (lb_bank !== exp_bank) bank_bad++;
      if (int'(lb_addr) != n_lb) lbaddr_bad++;
      if (lb_wdata !== pix(17'(exp_base + int'(lb_addr)))) data_bad++;
      n_lb++;
    end
    if (fetch_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (fetch_busy) begin
      if (n_busy == 0) busy_first = cyc;
      busy_last = cyc;
      n_busy++;
    end
  endtask

  // Inputs are set just after a rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int last);
    while (cyc <= last) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [7:0] line);
    fetch_start = 1'b1;
    fetch_line  = line;
    tick();
    fetch_start = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {fetch_busy, fetch_done, lb_we, lb_bank, lb_addr, lb_wdata, wr_ready,
            mem_addr, mem_re, mem_we, mem_wdata, err_overrun};
  endfunction

  typedef struct {
    logic        vld;
    logic [16:0] addr;
    logic [23:0] data;
    logic        exp_rdy;
    logic        exp_we;
  } wvec_t;

  wvec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 17'd1000,   24'hA5C3F0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 17'd76800,  24'h123456, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 17'd76799,  24'h0F0F0F, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 17'd1000,   24'hA5C3F0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 17'd131071, 24'hFFFFFF, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 17'd0,      24'hFFFFFF, 1'b1, 1'b1};

    fetch_start = 1'b0; fetch_line = 8'd0;
    wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 24'h777777;
    win_lo = 0; win_hi = -1;
    rst_n = 1'b0;
    #12;
    chk("reset_outputs_zero", longint'(all_outs()), 0);
    wr_valid = 1'b0;
    do_reset();

    // Line 0, writer idle.
    clear_stats(0, 1'b0);
    start_fetch(8'd0);
    run_to(330);
    chk("t1_reads", n_re, 320);
    chk("t1_first_read", first_re, 1);
    chk("t1_last_read", last_re, 320);
    chk("t1_addr_seq_bad", addr_bad, 0);
    chk("t1_lbwe_count", n_lb, 320);
    chk("t1_first_lbwe", first_lb, 2);
    chk("t1_last_lbwe", last_lb, 321);
    chk("t1_bank_bad", bank_bad, 0);
    chk("t1_lbaddr_bad", lbaddr_bad, 0);
    chk("t1_lbdata_bad", data_bad, 0);
    chk("t1_done_cycle", done_cyc, 321);
    chk("t1_done_count", n_done, 1);
    chk("t1_busy_first", busy_first, 1);
    chk("t1_busy_last", busy_last, 321);
    chk("t1_busy_count", n_busy, 321);

    // Line 239 with the writer hammering addr 5: slots alternate, writer first.
    wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 24'h0ABCDE;
    clear_stats(239 * 320, 1'b1);
    win_lo = 1; win_hi = 640;
    start_fetch(8'd239);
    run_to(660);
    wr_valid = 1'b0;
    win_hi = -1;
    chk("t2_reads", n_re, 320);
    chk("t2_first_read", first_re, 2);
    chk("t2_last_read", last_re, 640);
    chk("t2_reads_on_odd_cycles", re_odd, 0);
    chk("t2_addr_seq_bad", addr_bad, 0);
    chk("t2_done_cycle", done_cyc, 641);
    chk("t2_writer_grants", n_gwin, 320);
    chk("t2_re_we_overlap", n_both, 0);
    chk("t2_bank_bad", bank_bad, 0);
    chk("t2_lbdata_bad", data_bad, 0);
    chk("t2_err_clear", err_overrun, 0);

    // Back-to-back fetches; a start on the done cycle is refused.
    clear_stats(10 * 320, 1'b0);
    start_fetch(8'd10);
    begin
      int dcyc = -1;
      logic err_at_d = 1'b1;
      while (cyc <= 340) begin
        if (fetch_done && dcyc < 0) begin
          dcyc = cyc;
          err_at_d = err_overrun;
          fetch_start = 1'b1;
          fetch_line = 8'd20;
        end
        tick();
        fetch_start = 1'b0;
      end
      chk("t3_done_cycle_seen", dcyc, 321);
      chk("t3_err_before_refusal", err_at_d, 0);
    end
    chk("t3_err_set", err_overrun, 1);
    chk("t3_refused_no_reads", n_re, 320);
    chk("t3_busy_last", busy_last, 321);
    chk("t3a_bank_bad", bank_bad, 0);
    chk("t3a_lbwe_count", n_lb, 320);
    clear_stats(20 * 320, 1'b1);
    start_fetch(8'd20);
    run_to(330);
    chk("t3b_lbwe_count", n_lb, 320);
    chk("t3b_bank_bad", bank_bad, 0);
    chk("t3b_lbdata_bad", data_bad, 0);
    chk("t3b_done_cycle", done_cyc, 321);

    // Illegal line.
    do_reset();
    chk("t4_err_after_reset", err_overrun, 0);
    clear_stats(0, 1'b0);
    start_fetch(8'd240);
    run_to(20);
    chk("t4_no_reads", n_re, 0);
    chk("t4_no_lbwe", n_lb, 0);
    chk("t4_no_busy", n_busy, 0);
    chk("t4_err_set", err_overrun, 1);
    run_to(80);
    chk("t4_err_sticky", err_overrun, 1);
    rst_n = 1'b0;
    #1;
    chk("t4_err_cleared_by_reset", err_overrun, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Writer vectors in IDLE.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_valid = tbl[i].vld;
      wr_addr  = tbl[i].addr;
      wr_data  = tbl[i].data;
      @(negedge clk);
      chk($sformatf("w%0d_ready", i), wr_ready, tbl[i].exp_rdy);
      chk($sformatf("w%0d_we", i), mem_we, tbl[i].exp_we);
      chk($sformatf("w%0d_re", i), mem_re, 0);
      if (tbl[i].exp_we) begin
        chk($sformatf("w%0d_addr", i), mem_addr, tbl[i].addr);
        chk($sformatf("w%0d_wdata", i), mem_wdata, tbl[i].data);
      end
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;

    // Reset in the middle of a fetch.
    do_reset();
    clear_stats(3 * 320, 1'b0);
    start_fetch(8'd3);
    run_to(99);
    chk("t6_reading_before_reset", mem_re, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_outputs_zero", longint'(all_outs()), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_stats(0, 1'b0);
    run_to(400);
    chk("t6_no_lbwe_after_abort", n_lb, 0);
    chk("t6_no_done_after_abort", n_done, 0);
    chk("t6_no_reads_after_abort", n_re, 0);
    clear_stats(7 * 320, 1'b0);
    start_fetch(8'd7);
    run_to(330);
    chk("t6_refetch_lbwe_count", n_lb, 320);
    chk("t6_refetch_bank0", bank_bad, 0);
    chk("t6_refetch_data_bad", data_bad, 0);
    chk("t6_refetch_done", done_cyc, 321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
